// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin/round session sequencer.
package coin_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_COIN = 3'd1,
        COLLECT   = 3'd2,
        READY     = 3'd3,
        PLAY      = 3'd4,
        REFUND    = 3'd5
    } game_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_r;

    // Prescaler counter, cleared whenever the insert window is not open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!en || (cnt_r == LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/coin_round_ctrl.sv
// Game-session sequencer: coin counting, insert timeout and round granting.
// Optional feature macro COIN_REFUND_EN: timeout refunds every credited coin.
module coin_round_ctrl
    import coin_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
`ifdef COIN_REFUND_EN
    , parameter int REFUND_GAP = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] coins_to_insert,
    input  logic [CNT_W-1:0] coin_num_per_round,
    input  logic [CNT_W-1:0] wait_time_for_insert,
    input  logic             coin_pulse,
    input  logic             start_btn,
    input  logic             round_done,
    output logic             round_start,
    output logic             round_active,
    output logic [CNT_W-1:0] credit,
    output logic [CNT_W-1:0] rounds_left,
    output logic [CNT_W-1:0] time_left,
    output logic             refund_pulse
);

`ifdef COIN_REFUND_EN
    localparam game_state_t TIMEOUT_STATE = REFUND;
    localparam int GAP_W = (REFUND_GAP > 1) ? $clog2(REFUND_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFUND_GAP - 1);
    logic [GAP_W-1:0] gap_r;
    logic             refund_pulse_r;
`else
    localparam game_state_t TIMEOUT_STATE = WAIT_COIN;
`endif

    game_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0] price_r, rounds_r, wait_r;
    logic [CNT_W-1:0] credit_r, rounds_left_r, time_left_r;
    logic [CNT_W-1:0] credit_inc_s, credit_nxt_s;
    logic             round_start_r, round_active_r;
    logic             coin_ok_s, charge_s, tick_s, tick_en_s, refund_fire_s;

    assign tick_en_s = (state_r == COLLECT);

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en_s),
        .tick  (tick_s)
    );

`ifdef COIN_REFUND_EN
    assign refund_fire_s = (state_r == REFUND) && (gap_r == GAP_LAST) && (credit_r != 4'd0);
`else
    assign refund_fire_s = 1'b0;
`endif

    // Next-state decode; a coin always beats a simultaneous final tick.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_valid) state_nxt_s = WAIT_COIN;
                else           state_nxt_s = IDLE;
            end
            WAIT_COIN: begin
                if (!cfg_valid)                   state_nxt_s = IDLE;
                else if (credit_inc_s >= price_r) state_nxt_s = READY;
                else if (coin_ok_s)               state_nxt_s = COLLECT;
                else                              state_nxt_s = WAIT_COIN;
            end
            COLLECT: begin
                if (credit_inc_s >= price_r)                  state_nxt_s = READY;
                else if (coin_ok_s)                           state_nxt_s = COLLECT;
                else if (tick_s && (time_left_r == 4'd1))     state_nxt_s = TIMEOUT_STATE;
                else                                          state_nxt_s = COLLECT;
            end
            READY: begin
                if (start_btn) state_nxt_s = PLAY;
                else           state_nxt_s = READY;
            end
            PLAY: begin
                if (!round_done)                 state_nxt_s = PLAY;
                else if (rounds_left_r <= 4'd1)  state_nxt_s = WAIT_COIN;
                else                             state_nxt_s = READY;
            end
            REFUND: begin
                if (credit_r == 4'd0) state_nxt_s = WAIT_COIN;
                else                  state_nxt_s = TIMEOUT_STATE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Credit datapath: price is charged only when READY is reached from a paying state.
    always_comb begin
        coin_ok_s    = coin_pulse && (state_r != IDLE) && (state_r != REFUND);
        credit_inc_s = coin_ok_s ? sat_inc(credit_r) : credit_r;
        charge_s     = (state_nxt_s == READY) && ((state_r == WAIT_COIN) || (state_r == COLLECT));
        credit_nxt_s = refund_fire_s ? (credit_r - 4'd1)
                     : (charge_s ? (credit_inc_s - price_r) : credit_inc_s);
    end

    // State, shadow config, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            price_r        <= 4'd0;
            rounds_r       <= 4'd0;
            wait_r         <= 4'd0;
            credit_r       <= 4'd0;
            rounds_left_r  <= 4'd0;
            time_left_r    <= 4'd0;
            round_start_r  <= 1'b0;
            round_active_r <= 1'b0;
`ifdef COIN_REFUND_EN
            gap_r          <= '0;
            refund_pulse_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            credit_r <= credit_nxt_s;
            if ((state_r == IDLE) && cfg_valid) begin
                price_r  <= coins_to_insert;
                rounds_r <= (coin_num_per_round == 4'd0) ? 4'd1 : coin_num_per_round;
                wait_r   <= wait_time_for_insert;
            end
            if (charge_s) begin
                rounds_left_r <= rounds_r;
            end else if ((state_r == PLAY) && round_done && (rounds_left_r != 4'd0)) begin
                rounds_left_r <= rounds_left_r - 4'd1;
            end
            // A zero wait time loads 0 and never counts, which disables the timeout.
            if (state_nxt_s != COLLECT) begin
                time_left_r <= 4'd0;
            end else if (coin_ok_s) begin
                time_left_r <= wait_r;
            end else if (tick_s && (time_left_r != 4'd0)) begin
                time_left_r <= time_left_r - 4'd1;
            end
            round_start_r  <= (state_nxt_s == PLAY) && (state_r != PLAY);
            round_active_r <= (state_nxt_s == PLAY);
`ifdef COIN_REFUND_EN
            gap_r          <= ((state_r != REFUND) || (gap_r == GAP_LAST)) ? '0 : gap_r + GAP_W'(1);
            refund_pulse_r <= refund_fire_s;
`endif
        end
    end

    assign credit       = credit_r;
    assign rounds_left  = rounds_left_r;
    assign time_left    = time_left_r;
    assign round_start  = round_start_r;
    assign round_active = round_active_r;
`ifdef COIN_REFUND_EN
    assign refund_pulse = refund_pulse_r;
`else
    assign refund_pulse = 1'b0;
`endif

endmodule
